combo_lock_ctrl: RTL and testbench

Sequential controller for the 6-bit digital combination lock. It arms on `en`, takes a submitted 6-bit entry and compares it against a fixed passcode. It counts down remaining attempts, holds timed OPEN/DENIED/LOCKOUT phases, and emits a display-mode code. The code is consumed by the combinational 7-segment message decoder that renders CLOSED / tries-remaining / OPEN / DENIED on led5..led0.

---
 rtl/combo_lock_ctrl.sv | 101 ++++++++++
 tb/tb_combo_lock_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: combination-lock sequencer producing display mode, attempts and unlock
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   en                  - lock enable level
//   submit              - debounced submit button level (rising edge = one try)
//   entry[5:0]          - combination, sampled on an accepted submit
//   mode[2:0]           - 0 CLOSED, 1 TRYS, 2 OPEN, 3 DENIED, 4 LOCKED
//   attempts_left[1:0]  - remaining tries
//   unlock              - high exactly while OPEN
module combo_lock_ctrl #(
  parameter logic [5:0] PASSCODE       = 6'b101001,
  parameter int         MAX_ATTEMPTS   = 3,
  parameter int         OPEN_CYCLES    = 50_000_000,
  parameter int         DENIED_CYCLES  = 25_000_000,
  parameter int         LOCKOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       submit,
  input  logic [5:0] entry,
  output logic [2:0] mode,
  output logic [1:0] attempts_left,
  output logic       unlock
);
  localparam int MAXC = (OPEN_CYCLES > DENIED_CYCLES)
                        ? ((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES)
                        : ((DENIED_CYCLES > LOCKOUT_CYCLES) ? DENIED_CYCLES : LOCKOUT_CYCLES);
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    OPEN    = 3'd2,
    DENIED  = 3'd3,
    LOCKOUT = 3'd4
  } state_t;
  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    cnt_n;
  logic          submit_q;
  logic          expired;
  logic          accept;
  assign expired = (timer == '0);
  assign accept  = submit & ~submit_q;
  always_comb begin
    state_n = state;
    cnt_n   = attempts_left;
    timer_n = timer - TW'(1);
    case (state)
      IDLE: state_n = en ? READY : IDLE;
      READY: begin
        // en low wins over a simultaneous submit edge: no compare, counter kept
        if (!en) state_n = IDLE;
        else if (accept) begin
          if (entry == PASSCODE) begin
            state_n = OPEN;
            cnt_n   = 2'(MAX_ATTEMPTS);
            timer_n = TW'(OPEN_CYCLES - 1);
          end else begin
            state_n = DENIED;
            cnt_n   = (attempts_left == '0) ? 2'd0 : attempts_left - 2'd1;
            timer_n = TW'(DENIED_CYCLES - 1);
          end
        end
      end
      OPEN: state_n = !en ? IDLE : expired ? READY : OPEN;
      DENIED: begin
        // with no attempts left the phase is committed to lockout and ignores en
        if (expired && attempts_left == '0) begin
          state_n = LOCKOUT;
          timer_n = TW'(LOCKOUT_CYCLES - 1);
        end else if (expired || (!en && attempts_left != '0))
          state_n = en ? READY : IDLE;
      end
      LOCKOUT: begin
        if (expired) begin
          state_n = en ? READY : IDLE;
          cnt_n   = 2'(MAX_ATTEMPTS);
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      submit_q      <= 1'b0;
      attempts_left <= 2'(MAX_ATTEMPTS);
      mode          <= 3'd0;
      unlock        <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      submit_q      <= submit;
      attempts_left <= cnt_n;
      mode          <= state_n;
      unlock        <= (state_n == OPEN);
    end
  end
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: table-driven, hand-sequenced and randomized checks of combo_lock_ctrl
module tb_combo_lock_ctrl;
  localparam logic [5:0] P  = 6'b101001;
  localparam logic [5:0] W  = 6'b000000;
  localparam int MAXA = 3;
  localparam int OPN  = 4;
  localparam int DEN  = 2;
  localparam int LCK  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       submit;
  logic [5:0] entry;
  logic [2:0] mode;
  logic [1:0] attempts_left;
  logic       unlock;

  int n_chk  = 0;
  int n_fail = 0;

  combo_lock_ctrl #(
    .PASSCODE(P), .MAX_ATTEMPTS(MAXA), .OPEN_CYCLES(OPN),
    .DENIED_CYCLES(DEN), .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .submit(submit), .entry(entry),
    .mode(mode), .attempts_left(attempts_left), .unlock(unlock)
  );

  always #5 clk = ~clk;

  // reference model: phase number, cycles remaining in the timed phase, tries left
  int ph, rem, left;
  bit prev, ed;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; rem = 0; left = MAXA; prev = 0;
    end else begin
      ed   = submit && !prev;
      prev = submit;
      if (ph == 0) begin
        if (en) ph = 1;
      end else if (ph == 1) begin
        if (!en) ph = 0;
        else if (ed) begin
          if (entry == P) begin ph = 2; rem = OPN; left = MAXA; end
          else begin ph = 3; rem = DEN; left = (left > 0) ? left - 1 : 0; end
        end
      end else if (ph == 2) begin
        rem--;
        if (!en) ph = 0;
        else if (rem == 0) ph = 1;
      end else if (ph == 3) begin
        rem--;
        if (rem == 0) begin
          if (left == 0) begin ph = 4; rem = LCK; end
          else ph = en ? 1 : 0;
        end else if (!en && left > 0) ph = 0;
      end else begin
        rem--;
        if (rem == 0) begin left = MAXA; ph = en ? 1 : 0; end
      end
    end
  end

  typedef struct {
    logic       en;
    logic       sub;
    logic [5:0] ent;
    logic [2:0] mode;
    logic [1:0] left;
    logic       unl;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic e, logic s, logic [5:0] n, logic [2:0] m, logic [1:0] l, logic u);
    vec_t v;
    v.en = e; v.sub = s; v.ent = n; v.mode = m; v.left = l; v.unl = u;
    tbl.push_back(v);
  endfunction

  task automatic check(string nm, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk3(string nm, int m, int l, int u);
    check({nm, ".mode"}, int'(mode), m);
    check({nm, ".left"}, int'(attempts_left), l);
    check({nm, ".unlock"}, int'(unlock), u);
  endtask

  task automatic chk_model(string nm);
    check({nm, ".mode"}, int'(mode), ph);
    check({nm, ".left"}, int'(attempts_left), left);
    check({nm, ".unlock"}, int'(unlock), (ph == 2) ? 1 : 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; submit = 1'b0; entry = W;
    add(1,0,W, 1,3,0);
    add(1,1,P, 2,3,1);
    for (int i = 0; i < 3; i++) add(1,0,P, 2,3,1);
    add(1,0,W, 1,3,0);
    add(1,1,W, 3,2,0);
    add(1,0,W, 3,2,0);
    add(1,0,W, 1,2,0);
    add(1,1,W, 3,1,0);
    add(1,0,W, 3,1,0);
    add(1,0,W, 1,1,0);
    add(1,1,W, 3,0,0);
    add(0,0,W, 3,0,0);
    add(0,0,W, 4,0,0);
    for (int i = 0; i < 7; i++) add(logic'(i % 2 == 0), logic'(i == 2 || i == 3), P, 4,0,0);
    add(1,0,W, 1,3,0);
    add(0,1,P, 0,3,0);
    add(0,0,P, 0,3,0);
    add(1,1,P, 1,3,0);
    add(1,1,P, 1,3,0);
    add(1,0,P, 1,3,0);

    repeat (2) @(negedge clk);
    chk3("reset", 0, MAXA, 0);
    rst_n = 1'b1;
    tick();
    chk3("idle_after_reset", 0, MAXA, 0);

    foreach (tbl[i]) begin
      en = tbl[i].en; submit = tbl[i].sub; entry = tbl[i].ent;
      tick();
      chk3($sformatf("vec%0d", i), int'(tbl[i].mode), int'(tbl[i].left), int'(tbl[i].unl));
    end

    en = 1'b1; submit = 1'b1; entry = W;
    tick();
    chk3("held_first", 3, 2, 0);
    repeat (9) tick();
    chk3("held_end", 1, 2, 0);
    submit = 1'b0;
    tick();
    en = 1'b0;
    tick();
    chk3("en_drop", 0, 2, 0);
    en = 1'b1;
    tick();
    chk3("en_restore", 1, 2, 0);
    submit = 1'b1; entry = P;
    tick();
    chk3("reload_open", 2, 3, 1);
    submit = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 chk3("reset_mid_open", 0, 3, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk3("after_reset_open", 0, 3, 0);

    en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      submit = 1'b1; entry = W;
      tick();
      submit = 1'b0;
      tick();
      tick();
    end
    chk3("lockout_entry", 4, 0, 0);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1 chk3("reset_mid_lockout", 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_model("model_sync");

    for (int k = 0; k < 400; k++) begin
      en     = ($urandom_range(0, 9) != 0);
      submit = 1'($urandom_range(0, 1));
      entry  = ($urandom_range(0, 1) != 0) ? P : 6'($urandom_range(0, 63));
      tick();
      chk_model($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
